// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for NDIG 7-segment digits.
// BCD digits are double-buffered (pending -> active) so that a frame never
// tears. One digit is shown per REFRESH_DIV clocks. All outputs are registered.
module seven_seg_scanner #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     dig_en,
    output logic                frame_done
);

    localparam int IDX_W = $clog2(NDIG);
    localparam int DIV_W = $clog2(REFRESH_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DIV_W-1:0]  div;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] pending;
    logic [4*NDIG-1:0] active;
    logic              frame_start;   // first cycle of a new frame internally

    logic              tick;
    logic              wrap;

    logic [3:0]        cur_digit;
    logic              upper_nz;      // selected digit or any above it is non-zero
    logic              blank;
    logic [6:0]        seg_d;
    logic [NDIG-1:0]   en_d;

    assign tick = (div == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Refresh divider and scan index; the index wrap is the frame boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            idx <= '0;
        end else begin
            if (tick) begin
                div <= '0;
                if (idx == IDX_LAST) idx <= '0;
                else                 idx <= idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending; active only moves at the boundary,
    // and a load on the boundary cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending     <= '0;
            active      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (load) pending <= bcd_in;
            if (wrap) active  <= load ? bcd_in : pending;
            frame_start <= wrap;
        end
    end

    // Select the scanned digit and find whether any digit at or above it is non-zero.
    always_comb begin
        cur_digit = '0;
        upper_nz  = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (IDX_W'(i) == idx) cur_digit = active[4*i +: 4];
            if ((IDX_W'(i) >= idx) && (active[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
        end
    end

    // BCD to segments {a,b,c,d,e,f,g}; invalid codes show a dash.
    always_comb begin
        seg_d = 7'b0000001;
        case (cur_digit)
            4'd0: seg_d = 7'b1111110;
            4'd1: seg_d = 7'b0110000;
            4'd2: seg_d = 7'b1101101;
            4'd3: seg_d = 7'b1111001;
            4'd4: seg_d = 7'b0110011;
            4'd5: seg_d = 7'b1011011;
            4'd6: seg_d = 7'b1011111;
            4'd7: seg_d = 7'b1110000;
            4'd8: seg_d = 7'b1111111;
            4'd9: seg_d = 7'b1111011;
            default: seg_d = 7'b0000001;
        endcase
    end

    assign blank = (BLANK_LZ != 0) && (idx != '0) && !upper_nz;
    assign en_d  = NDIG'(1) << idx;

    // Output register: segment bus and digit enable always update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg        <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= blank ? 7'b0000000 : seg_d;
            dig_en     <= en_d;
            frame_done <= frame_start;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed and random stimulus against a frame-level
// reference model, for both leading-zero blanking settings.
module tb_seven_seg_scanner;

    localparam int NDIG  = 4;
    localparam int RD    = 4;
    localparam int FRAME = NDIG * RD;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [6:0]  seg,  seg_nb;
    logic [3:0]  dig_en, dig_en_nb;
    logic        frame_done, frame_done_nb;

    int compared   = 0;
    int mismatched = 0;

    // Model state: edges since reset release, displayed value, pending value.
    int          n     = 0;
    logic [15:0] shown = '0;
    logic [15:0] pend  = '0;
    logic [6:0]  seg_tab [16];

    seven_seg_scanner #(.NDIG(NDIG), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
    );

    seven_seg_scanner #(.NDIG(NDIG), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .seg(seg_nb), .dig_en(dig_en_nb), .frame_done(frame_done_nb)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at n=%0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    // Expected segments for digit position d of value v.
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit lz);
        logic [15:0] upper;
        logic [3:0]  code;
        upper = v >> (4 * d);
        code  = upper[3:0];
        if (lz && d > 0 && upper == 16'd0) return 7'b0000000;
        return seg_tab[code];
    endfunction

    // One clock: drive inputs, advance model, check both instances.
    task automatic cyc(input logic ld, input logic [15:0] bcd, input logic r);
        logic [6:0] es, es_nb;
        logic [3:0] ee;
        logic       ef;
        int         d;
        rst    = r;
        load   = ld;
        bcd_in = bcd;
        @(posedge clk);
        if (!r) begin
            n = 0; shown = '0; pend = '0;
            es = '0; es_nb = '0; ee = '0; ef = 1'b0;
        end else begin
            n++;
            d     = ((n - 1) / RD) % NDIG;
            es    = exp_seg(shown, d, 1'b1);
            es_nb = exp_seg(shown, d, 1'b0);
            ee    = 4'(1 << d);
            ef    = (n > 1) && ((n - 1) % FRAME == 0);
            if (n % FRAME == 0) shown = ld ? bcd : pend;
            if (ld) pend = bcd;
        end
        #1;
        chk("seg",           32'(seg),           32'(es));
        chk("dig_en",        32'(dig_en),        32'(ee));
        chk("frame_done",    32'(frame_done),    32'(ef));
        chk("seg_nb",        32'(seg_nb),        32'(es_nb));
        chk("dig_en_nb",     32'(dig_en_nb),     32'(ee));
        chk("frame_done_nb", 32'(frame_done_nb), 32'(ef));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
        seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
        seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
        seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
        seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;

        rst = 1'b0; load = 1'b0; bcd_in = '0;

        // Reset held 3 cycles, then scan of all-zero value
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b0);
        idle(21);

        // Mid-frame load of 1234
        cyc(1'b1, 16'h1234, 1'b1);
        idle(40);

        // Leading-zero blanking
        cyc(1'b1, 16'h0070, 1'b1);
        idle(40);

        // Invalid code shows a dash and counts as non-zero
        cyc(1'b1, 16'h00A5, 1'b1);
        idle(40);

        // Two loads in one frame, the second exactly on the boundary
        while ((n + 1) % FRAME != 7) idle(1);
        cyc(1'b1, 16'h0003, 1'b1);
        while ((n + 1) % FRAME != 0) idle(1);
        cyc(1'b1, 16'h0009, 1'b1);
        idle(20);

        // One-cycle reset mid-frame with a concurrent load
        cyc(1'b1, 16'h8888, 1'b1);
        idle(10);
        while ((n + 1) % FRAME != 5) idle(1);
        cyc(1'b1, 16'h5555, 1'b0);
        idle(40);

        // Random loads (including invalid codes), occasional resets
        for (int i = 0; i < 600; i++) begin
            logic        ld;
            logic        r;
            logic [15:0] v;
            ld = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 199) != 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
            cyc(ld, v, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Multiplexed multi-digit 7-segment display driver that sits directly downstream of the BCD counter stage. It accepts a packed vector of BCD digits, double-buffers them so frames never tear, and time-multiplexes one shared `seg[6:0]` bus across `NDIG` digit enables. Decoding covers digits 0–9, shows a dash for invalid codes, and optionally blanks leading zeros.

## Interface
Parameters:
- `NDIG`, 4: number of digits scanned (2–8).
- `REFRESH_DIV`, 1000: clock cycles each digit is held (≥2).
- `BLANK_LZ`, 1: 1 = blank leading zeros, 0 = show all digits.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `load`  in  1  capture strobe for `bcd_in`, one cycle.
- `bcd_in`  in  4*NDIG  packed digits; `[3:0]` = digit 0 (least significant).
- `seg`  out  7  segments `{a,b,c,d,e,f,g}`, active-high (1 = lit).
- `dig_en`  out  NDIG  one-hot digit enable, active-high; bit i selects digit i.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Divider `div` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when `div == REFRESH_DIV-1`.
- Scan index `idx` counts 0..NDIG-1 and advances on `tick`, wrapping from NDIG-1 to 0. The wrap is the frame boundary.
- Two buffers, `pending` and `active`, each 4*NDIG bits:
  - `load=1`: `pending <= bcd_in`.
  - At the frame boundary: `active <= load ? bcd_in : pending`. The same-cycle load wins.
  - `active` changes only at the frame boundary.
- Decode of the selected `active` digit:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - 10–15 = 0000001 (dash).
- Leading-zero blanking (`BLANK_LZ=1`):
  - Digit i > 0 is blanked (`seg = 0000000`) when it and every more-significant digit equal 0.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - `dig_en` still asserts for blanked digits.
- Reset values:
  - `div`, `idx` = 0.
  - `pending`, `active` = all zeros.
  - Outputs: `seg = 0000000`, `dig_en = 0`, `frame_done = 0`.
- Reset asserted mid-frame overrides everything in the same edge, including a concurrent `load`.

## Timing
- All outputs are registered and reflect `idx`/`active` with one cycle of latency.
- First cycle after reset release: `seg = 1111110`, `dig_en = 0001` (digit 0 shows "0", digits 1..3 blanked).
- Each digit is held for exactly REFRESH_DIV cycles. A frame is NDIG*REFRESH_DIV cycles.
- `dig_en` and `seg` always change in the same cycle. The bus is never driven with a mismatched digit/segment pair.
- `frame_done`:
  - Pulses high for one cycle, in the same output cycle where `dig_en` returns to bit 0 and the new `active` value first appears.
  - It does not pulse on the first cycle after reset.
- A `load` takes effect on the display at the next frame boundary:
  - Worst case NDIG*REFRESH_DIV cycles later.
  - Best case on the boundary itself (same-cycle load).
- Multiple loads within one frame: only the last one is displayed.

## Test plan
Run with `NDIG=4`, `REFRESH_DIV=4`.
1. Reset held low 3 cycles, then released -> during reset `seg=0000000`, `dig_en=0000`, `frame_done=0`. First cycle after release `seg=1111110`, `dig_en=0001`. `dig_en` steps 0001→0010→0100→1000 every 4 cycles.
2. `load` with `bcd_in=16'h1234` mid-frame -> display unchanged until the boundary. Then digit0 `seg=0110011` ("4"), digit3 `seg=0110000` ("1"). `frame_done` pulses once per 16 cycles.
3. `bcd_in=16'h0070` -> digits 3 and 2 `seg=0000000` with `dig_en` still asserted, digit1 `1110000`, digit0 `1111110`. Repeat with `BLANK_LZ=0` -> digits 3 and 2 show `1111110`.
4. `bcd_in=16'h00A5` -> digit1 `0000001` (dash), digit0 `1011011`, digits 3 and 2 blanked.
5. `load` of `16'h0009` asserted exactly on the boundary cycle, plus a second load `16'h0003` earlier in the same frame -> the boundary load wins and digit0 shows `1111011`.
6. Reset pulsed low for one cycle mid-frame while `load=1` -> all outputs return to reset values. The scan restarts at digit 0 showing "0", and the loaded value is discarded.
